eeprom_spi_ctrl: RTL and testbench

SPI-mode-0 master that sequences byte reads and writes to the on-board serial EEPROM through the eeprom_cs/eeprom_cclk/eeprom_so/eeprom_si pins. It accepts single-byte commands over a valid/ready handshake, generates the opcode, address and data frames, and returns one response pulse per command. It sits between fpga_top's EEPROM pins and internal configuration logic.

---
 rtl/eeprom_spi_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_eeprom_spi_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_spi_ctrl.sv
// SPI mode-0 master sequencing single-byte EEPROM reads/writes (WREN, READ/WRITE frames).
// Define EEPROM_WIP_POLL_EN to add RDSR polling of the WIP bit after each write.
module eeprom_spi_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_W     = 16,
    parameter int CS_HOLD    = 2,
    parameter int POLL_LIMIT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              eeprom_cs,
    output logic              eeprom_cclk,
    output logic              eeprom_so,
    input  logic              eeprom_si
);

    localparam int FRAME_W = 16 + ADDR_W;
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int GAP_W   = $clog2(CS_HOLD + 1);

    if (CLK_DIV < 1 || ADDR_W < 8 || (ADDR_W % 8) != 0 || CS_HOLD < 1 || POLL_LIMIT < 1) begin : g_param_check
        $error("eeprom_spi_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_XFER,
`ifdef EEPROM_WIP_POLL_EN
        S_POLL,
`endif
        S_RESP
    } state_t;

    state_t              state, state_nxt, prev;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wdata_q;
    logic [FRAME_W-1:0]  shreg, shifted;
    logic                miso_bit;
    logic                sck;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt, frame_len;
    logic [GAP_W-1:0]    gap_cnt;
    logic [7:0]          hold_rdata;
    logic                in_frame, nxt_frame, frame_done, gap_done, load_frame;
`ifdef EEPROM_WIP_POLL_EN
    localparam int PW = $clog2(POLL_LIMIT + 1);
    logic [PW-1:0]       poll_cnt;
`endif

    always_comb begin
        in_frame  = (state == S_WREN) || (state == S_XFER);
        nxt_frame = (state_nxt == S_WREN) || (state_nxt == S_XFER);
        frame_len = BIT_W'(8);
        case (state)
            S_XFER:  frame_len = BIT_W'(FRAME_W);
`ifdef EEPROM_WIP_POLL_EN
            S_POLL:  frame_len = BIT_W'(16);
`endif
            default: frame_len = BIT_W'(8);
        endcase
`ifdef EEPROM_WIP_POLL_EN
        in_frame  = in_frame || (state == S_POLL);
        nxt_frame = nxt_frame || (state_nxt == S_POLL);
`endif
        // a frame ends on the SCK falling edge of its last bit
        frame_done = in_frame && sck && (div_cnt == DIV_W'(CLK_DIV - 1))
                     && (bit_cnt == frame_len - 1'b1);
        gap_done   = (state == S_GAP) && (gap_cnt == GAP_W'(CS_HOLD - 1));
        load_frame = nxt_frame && (state_nxt != state);
        shifted    = {shreg[FRAME_W-2:0], miso_bit};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cmd_valid) state_nxt = cmd_write ? S_WREN : S_XFER;
            S_GAP: begin
                if (gap_done) begin
                    case (prev)
                        S_WREN: state_nxt = S_XFER;
`ifdef EEPROM_WIP_POLL_EN
                        S_XFER: state_nxt = wr_q ? S_POLL : S_RESP;
                        S_POLL: state_nxt = (!hold_rdata[0] || poll_cnt == PW'(POLL_LIMIT))
                                            ? S_RESP : S_POLL;
`endif
                        default: state_nxt = S_RESP;
                    endcase
                end
            end
            S_RESP: state_nxt = S_IDLE;
            default: if (frame_done) state_nxt = S_GAP;
        endcase
    end

    always_comb begin
        cmd_ready   = (state == S_IDLE);
        rsp_valid   = (state == S_RESP);
        eeprom_cs   = !in_frame;
        eeprom_cclk = in_frame && sck;
        eeprom_so   = in_frame && shreg[FRAME_W-1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev       <= S_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            shreg      <= '0;
            miso_bit   <= 1'b0;
            sck        <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            hold_rdata <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef EEPROM_WIP_POLL_EN
            poll_cnt   <= '0;
`endif
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                wr_q       <= cmd_write;
                addr_q     <= cmd_addr;
                wdata_q    <= cmd_wdata;
                hold_rdata <= '0;
`ifdef EEPROM_WIP_POLL_EN
                poll_cnt   <= '0;
`endif
            end
            if (load_frame) begin
                sck     <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                shreg   <= '0;
                case (state_nxt)
                    // XFER straight from IDLE is always a read; from GAP it is the write frame
                    S_XFER: shreg <= (state == S_IDLE) ? {8'h03, cmd_addr, cmd_wdata}
                                                       : {8'h02, addr_q, wdata_q};
                    S_WREN: shreg[FRAME_W-1 -: 8] <= 8'h06;
`ifdef EEPROM_WIP_POLL_EN
                    S_POLL: shreg[FRAME_W-1 -: 8] <= 8'h05;
`endif
                    default: ;
                endcase
            end else if (in_frame) begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    sck     <= ~sck;
                    if (!sck) begin
                        miso_bit <= eeprom_si;
                    end else begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            if (frame_done) begin
                prev    <= state;
                gap_cnt <= '0;
                if (state == S_XFER && !wr_q) hold_rdata <= shifted[7:0];
`ifdef EEPROM_WIP_POLL_EN
                if (state == S_POLL) begin
                    hold_rdata <= shifted[7:0];
                    poll_cnt   <= poll_cnt + 1'b1;
                end
`endif
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (state_nxt == S_RESP && state != S_RESP) begin
                rsp_rdata <= hold_rdata;
`ifdef EEPROM_WIP_POLL_EN
                rsp_err   <= (prev == S_POLL) && hold_rdata[0];
`else
                rsp_err   <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_eeprom_spi_ctrl.sv
// Bench for eeprom_spi_ctrl: EEPROM slave model on the SPI pins plus frame/latency reference.
// Handles both the default build and EEPROM_WIP_POLL_EN.
module tb_eeprom_spi_ctrl;

    localparam int CLK_DIV    = 4;
    localparam int ADDR_W     = 16;
    localparam int CS_HOLD    = 2;
    localparam int POLL_LIMIT = 4;
    localparam int FRAME_W    = 16 + ADDR_W;
    localparam int BIT_CLK    = 2 * CLK_DIV;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [7:0]        cmd_wdata = '0;
    logic              rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              eeprom_cs, eeprom_cclk, eeprom_so;
    logic              eeprom_si = 1'b0;

    eeprom_spi_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .ADDR_W    (ADDR_W),
        .CS_HOLD   (CS_HOLD),
        .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .eeprom_cs  (eeprom_cs),
        .eeprom_cclk(eeprom_cclk),
        .eeprom_so  (eeprom_so),
        .eeprom_si  (eeprom_si)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          len;
        logic [63:0] val;
        int          low;
        int          gap;
    } frame_t;

    frame_t      frames[$];
    logic [7:0]  status_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          nbits   = 0;
    int          cur_low = 0;
    int          cur_gap = 0;
    int          hi_cnt  = 0;
    int          so_bad  = 0;
    logic [63:0] fr_val  = '0;
    logic        prev_cs = 1'b1;
    logic        prev_cclk = 1'b0;
    logic [7:0]  cur_op = '0;
    logic [7:0]  cur_status = '0;
    logic [7:0]  rd_byte = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic slave_bit(input int k);
        if (k >= 8 && cur_op == 8'h03 && k >= 8 + ADDR_W) return rd_byte[FRAME_W-1-k];
        if (k >= 8 && cur_op == 8'h05 && k < 16)          return cur_status[15-k];
        return 1'($urandom_range(0, 1));
    endfunction

    // EEPROM slave: watches pins on the falling system clock, drives MISO ahead of each SCK rise
    always @(negedge clock) begin
        if (!eeprom_cs) begin
            if (prev_cs) begin
                nbits   = 0;
                fr_val  = '0;
                cur_low = 0;
                cur_op  = '0;
                cur_gap = hi_cnt;
            end
            cur_low++;
            if (eeprom_cclk && !prev_cclk) begin
                fr_val = {fr_val[62:0], eeprom_so};
                nbits++;
                if (nbits == 8) begin
                    cur_op = fr_val[7:0];
                    if (cur_op == 8'h05)
                        cur_status = (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
                end
            end
            if (!eeprom_cclk) eeprom_si = slave_bit(nbits);
        end else begin
            if (!prev_cs) begin
                frames.push_back('{len: nbits, val: fr_val, low: cur_low, gap: cur_gap});
                hi_cnt = 1;
            end else begin
                hi_cnt++;
            end
            if (eeprom_so !== 1'b0) so_bad++;
            eeprom_si = 1'b0;
        end
        prev_cs   = eeprom_cs;
        prev_cclk = eeprom_cclk;
    end

    task automatic run_cmd(input bit wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                           input logic [7:0] rb, input bit noise);
        int         k;
        int         exp_lat;
        int         exp_n;
        int         npoll;
        logic [7:0] exp_rd;
        bit         exp_err;
        bit         ready_bad;
        logic [7:0] last;
        npoll   = 0;
        exp_err = 1'b0;
        exp_rd  = 8'h00;
        if (!wr) begin
            exp_rd  = rb;
            exp_lat = 1 + FRAME_W * BIT_CLK + CS_HOLD;
            exp_n   = 1;
        end else begin
`ifdef EEPROM_WIP_POLL_EN
            for (int i = 0; i < POLL_LIMIT; i++) begin
                last = (i < status_q.size()) ? status_q[i] : 8'h00;
                npoll++;
                if (!last[0]) break;
            end
            exp_rd  = last;
            exp_err = last[0];
`endif
            exp_lat = 1 + 8 * BIT_CLK + CS_HOLD + FRAME_W * BIT_CLK + CS_HOLD
                      + npoll * (16 * BIT_CLK + CS_HOLD);
            exp_n   = 2 + npoll;
        end

        @(negedge clock);
        check("ready_idle", cmd_ready, 1'b1);
        frames.delete();
        rd_byte   = rb;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clock);
        k = 0;
        ready_bad = 1'b0;
        while (1) begin
            @(negedge clock);
            k++;
            if (rsp_valid || k > 20000) break;
            if (cmd_ready) ready_bad = 1'b1;
            if (noise) begin
                cmd_addr  = ADDR_W'($urandom);
                cmd_wdata = 8'($urandom);
                cmd_write = 1'($urandom_range(0, 1));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("latency", k, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, exp_err);
        check("busy_ready", ready_bad, 1'b0);
        @(negedge clock);
        check("ready_after", cmd_ready, 1'b1);
        check("rsp_pulse", rsp_valid, 1'b0);
        check("frame_count", frames.size(), exp_n);
        for (int i = 0; i < frames.size() && i < exp_n; i++) begin
            if (!wr) begin
                check("rd_len", frames[i].len, FRAME_W);
                check("rd_mosi", frames[i].val >> 8, {8'h03, a});
            end else if (i == 0) begin
                check("wren_len", frames[i].len, 8);
                check("wren_mosi", frames[i].val, 8'h06);
            end else if (i == 1) begin
                check("wr_len", frames[i].len, FRAME_W);
                check("wr_mosi", frames[i].val, {8'h02, a, d});
            end else begin
                check("rdsr_len", frames[i].len, 16);
                check("rdsr_mosi", frames[i].val >> 8, 8'h05);
            end
            check("cs_low", frames[i].low, frames[i].len * BIT_CLK);
            if (i > 0) check("cs_gap", frames[i].gap, CS_HOLD);
        end
        status_q.delete();
    endtask

    initial begin
        int  waited;
        bit  rsp_seen;
        repeat (3) @(negedge clock);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_err", rsp_err, 1'b0);
        check("rst_cs", eeprom_cs, 1'b1);
        check("rst_cclk", eeprom_cclk, 1'b0);
        check("rst_so", eeprom_so, 1'b0);
        reset = 1'b1;

        run_cmd(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0);
        status_q.push_back(8'h00);
        run_cmd(1'b1, 16'h00FF, 8'h5A, 8'h00, 1'b0);
`ifdef EEPROM_WIP_POLL_EN
        status_q = '{8'h01, 8'h01, 8'h01, 8'h00};
        run_cmd(1'b1, 16'h0100, 8'h3C, 8'h00, 1'b0);
        status_q = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
        run_cmd(1'b1, 16'h0200, 8'hC3, 8'h00, 1'b0);
`endif
        run_cmd(1'b0, 16'hBEEF, 8'h11, 8'h5C, 1'b1);

        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h4321;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        waited = 0;
        while (nbits < 10 && waited < 1000) begin
            @(negedge clock);
            waited++;
        end
        check("reset_wait", (waited < 1000), 1'b1);
        #2 reset = 1'b0;
        #1;
        check("abort_cs", eeprom_cs, 1'b1);
        check("abort_cclk", eeprom_cclk, 1'b0);
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_so", eeprom_so, 1'b0);
        rsp_seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (rsp_valid) rsp_seen = 1'b1;
        end
        reset = 1'b1;
        repeat (CS_HOLD + 2) begin
            @(negedge clock);
            if (rsp_valid) rsp_seen = 1'b1;
        end
        check("abort_no_rsp", rsp_seen, 1'b0);
        run_cmd(1'b0, 16'h0F0F, 8'h00, 8'h96, 1'b0);

        for (int t = 0; t < 10; t++) begin
            bit wr;
            wr = 1'($urandom_range(0, 1));
            if (wr) begin
                int nb;
                nb = $urandom_range(0, 5);
                for (int j = 0; j < nb; j++) status_q.push_back(8'($urandom) | 8'h01);
                status_q.push_back(8'($urandom) & 8'hFE);
            end
            run_cmd(wr, ADDR_W'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        check("so_low_when_cs_high", so_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
